// File: rtl/alu_pkg.sv
// Shared definitions for the ALU iterative multiply/divide controller:
// FSM state encoding, operation codes, iteration constants and the
// result payload type.
package alu_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ITER  = 8;
  localparam int unsigned IDX_W = 3;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [WIDTH-1:0] DBZ_QUOT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // High half: product[15:8] / remainder; low half: product[7:0] / quotient.
  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } muldiv_res_t;

endpackage

// File: rtl/muldiv_step.sv
// Single-iteration combinational datapath shared by multiply and divide.
// Ports:
//   op       : 0 = multiply (shift-add), 1 = divide (restoring)
//   hi       : acc_hi (multiply) / remainder (divide)
//   lo       : acc_lo (multiply) / quotient-in-progress (divide)
//   operand  : multiplicand a (multiply) / divisor b (divide)
//   next_hi  : updated acc_hi / remainder
//   next_lo  : updated acc_lo / quotient
//   q_bit    : quotient bit produced by this divide iteration
module muldiv_step
  import alu_pkg::*;
(
  input  logic             op,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo,
  output logic             q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] diff;

  // The carry out of the add is shifted straight back into acc_hi, so no
  // carry register is needed between iterations.
  // The shifted partial remainder needs 9 bits; after a successful trial
  // subtraction it is below the divisor, so 8-bit wrap-around math is exact.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    part    = {hi, lo[WIDTH-1]};
    diff    = part[WIDTH-1:0] - operand;
    next_hi = '0;
    next_lo = '0;
    q_bit   = 1'b0;
    if (op == OP_MUL) begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], lo[WIDTH-1:1]};
    end else begin
      q_bit   = (part >= {1'b0, operand});
      next_hi = q_bit ? diff : part[WIDTH-1:0];
      next_lo = {lo[WIDTH-2:0], q_bit};
    end
  end

endmodule

// File: rtl/seq_muldiv_ctrl.sv
// Control FSM and registers for the 8-bit iterative unsigned multiply and
// divide. Drives the external 3-bit iteration counter and cross-checks it
// against an internal shadow index.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   start, op, a, b     : request, opcode (0 mul / 1 div), operands
//   cnt_count, cnt_done : iteration counter value and terminal flag
//   cnt_en, cnt_clr     : counter enable and clear
//   busy, valid         : operation in progress, one-cycle result strobe
//   result_hi/lo        : product / remainder,quotient
//   dbz, err            : divide-by-zero flag, sticky counter disagreement
module seq_muldiv_ctrl
  import alu_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [IDX_W-1:0] cnt_count,
  input  logic             cnt_done,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             dbz,
  output logic             err
);

  state_t           state_q, state_d;
  logic             op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [IDX_W-1:0] idx_q;
  muldiv_res_t      res_q;
  logic             busy_q, valid_q, cnt_en_q, cnt_clr_q, dbz_q, err_q;

  logic             accept, take_dbz, step_en, capture, err_set;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             step_q_bit;
  logic             last_idx;

  muldiv_step u_step (
    .op      (op_q),
    .hi      (hi_q),
    .lo      (lo_q),
    .operand ((op_q == OP_MUL) ? a_q : b_q),
    .next_hi (step_hi),
    .next_lo (step_lo),
    .q_bit   (step_q_bit)
  );

  assign last_idx = (idx_q == IDX_W'(ITER - 1));

  // Next-state and control decode.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    take_dbz = 1'b0;
    step_en  = 1'b0;
    capture  = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (op == OP_DIV && b == '0) begin
            take_dbz = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        step_en = 1'b1;
        if (cnt_count != idx_q) err_set = 1'b1;
        // Finish on the counter's terminal count, or force it when the
        // shadow index runs out; either disagreement is flagged.
        if (cnt_done || last_idx) begin
          capture = 1'b1;
          state_d = DONE;
          if (cnt_done != last_idx) err_set = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      idx_q     <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      dbz_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d == LOAD) || (state_d == RUN);
      valid_q   <= (state_d == DONE);
      cnt_en_q  <= (state_d == RUN);
      cnt_clr_q <= (state_d == LOAD);
      if (accept) begin
        op_q  <= op;
        a_q   <= a;
        b_q   <= b;
        dbz_q <= take_dbz;
      end
      if (take_dbz) res_q <= '{hi: a, lo: DBZ_QUOT};
      if (state_q == LOAD) begin
        hi_q  <= '0;
        lo_q  <= (op_q == OP_MUL) ? b_q : a_q;
        idx_q <= '0;
      end
      if (step_en) begin
        hi_q  <= step_hi;
        lo_q  <= step_lo;
        idx_q <= idx_q + IDX_W'(1);
      end
      if (capture) res_q <= '{hi: step_hi, lo: step_lo};
      if (err_set) err_q <= 1'b1;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q | RST;
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign result_hi = res_q.hi;
  assign result_lo = res_q.lo;
  assign dbz       = dbz_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_muldiv_ctrl.sv
// Self-checking bench for seq_muldiv_ctrl with a behavioural iteration
// counter and an arithmetic reference model.
module tb_seq_muldiv_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start, op;
  logic [7:0] a, b;
  logic [2:0] cnt_count;
  logic       cnt_done;
  logic       cnt_en, cnt_clr, busy, valid, dbz, err;
  logic [7:0] result_hi, result_lo;

  logic [2:0] cnt_q;
  logic       stuck;

  int n_checks = 0;
  int n_errors = 0;

  seq_muldiv_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .cnt_count (cnt_count),
    .cnt_done  (cnt_done),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .busy      (busy),
    .valid     (valid),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .dbz       (dbz),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  // 3-bit iteration counter; 'stuck' pins its outputs at zero.
  always_ff @(posedge CLK) begin
    if (cnt_clr)     cnt_q <= 3'd0;
    else if (cnt_en) cnt_q <= cnt_q + 3'd1;
  end
  assign cnt_count = stuck ? 3'd0 : cnt_q;
  assign cnt_done  = stuck ? 1'b0 : (cnt_q == 3'd7);

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation, optionally re-pulsing start in cycles p1/p2, and
  // check latency, result, flags and busy against the arithmetic model.
  task automatic run_op(input string tag, input logic o, input logic [7:0] x, input logic [7:0] y,
                        input int p1, input int p2, input logic exp_err);
    logic [15:0] exp_res;
    logic        exp_dbz;
    int          exp_lat, cyc, busy_bad;
    logic        got, saw_en;
    if (o && y == 8'd0) begin
      exp_res = {x, 8'hFF}; exp_dbz = 1'b1; exp_lat = 1;
    end else if (o) begin
      exp_res = {8'(x % y), 8'(x / y)}; exp_dbz = 1'b0; exp_lat = 10;
    end else begin
      exp_res = 16'(x * y); exp_dbz = 1'b0; exp_lat = 10;
    end
    @(negedge CLK);
    start = 1'b1; op = o; a = x; b = y;
    cyc = 0; got = 1'b0; saw_en = 1'b0; busy_bad = 0;
    while (!got && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      start = 1'b0;
      if (valid) got = 1'b1;
      else if (busy !== 1'b1) busy_bad++;
      if (cnt_en) saw_en = 1'b1;
      if (cyc == p1 || cyc == p2) begin
        start = 1'b1; op = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      end
    end
    chk({tag, ".got_valid"}, 16'(got), 16'd1);
    chk({tag, ".latency"}, 16'(cyc), 16'(exp_lat));
    chk({tag, ".result"}, {result_hi, result_lo}, exp_res);
    chk({tag, ".dbz"}, 16'(dbz), 16'(exp_dbz));
    chk({tag, ".err"}, 16'(err), 16'(exp_err));
    chk({tag, ".busy_run"}, 16'(busy_bad), 16'd0);
    chk({tag, ".busy_done"}, 16'(busy), 16'd0);
    if (exp_dbz) chk({tag, ".no_cnt_en"}, 16'(saw_en), 16'd0);
    @(negedge CLK);
    start = 1'b0;
    chk({tag, ".idle_after"}, {14'd0, busy, valid}, 16'd0);
  endtask

  initial begin
    int nv;
    logic       ro;
    logic [7:0] ra, rb;
    RST = 1'b1; start = 1'b0; op = 1'b0; a = 8'd0; b = 8'd0; stuck = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset.outs", {10'd0, busy, valid, dbz, err, cnt_en, cnt_clr}, 16'h0001);
    chk("reset.result", {result_hi, result_lo}, 16'h0000);
    RST = 1'b0;

    run_op("mul13x11", 1'b0, 8'd13, 8'd11, -1, -1, 1'b0);
    run_op("mul255x255", 1'b0, 8'd255, 8'd255, -1, -1, 1'b0);
    run_op("mul0x77", 1'b0, 8'd0, 8'd77, -1, -1, 1'b0);
    run_op("div200_7", 1'b1, 8'd200, 8'd7, -1, -1, 1'b0);
    run_op("div5_0", 1'b1, 8'd5, 8'd0, -1, -1, 1'b0);
    run_op("ignore_start", 1'b0, 8'd13, 8'd11, 3, 10, 1'b0);
    run_op("div255_1", 1'b1, 8'd255, 8'd1, -1, -1, 1'b0);
    run_op("div3_200", 1'b1, 8'd3, 8'd200, -1, -1, 1'b0);
    run_op("div255_128", 1'b1, 8'd255, 8'd128, -1, -1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ro = 1'($urandom);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op("rand", ro, ra, rb, -1, -1, 1'b0);
    end

    // Reset in cycle 5 of a multiply.
    @(negedge CLK);
    start = 1'b1; op = 1'b0; a = 8'd200; b = 8'd100;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("midrst.cnt_clr", 16'(cnt_clr), 16'd1);
    chk("midrst.busy_before", 16'(busy), 16'd1);
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst.idle", {13'd0, busy, valid, cnt_en}, 16'd0);
    chk("midrst.result", {result_hi, result_lo}, 16'h0000);
    nv = 0;
    repeat (12) begin
      @(negedge CLK);
      if (valid) nv++;
    end
    chk("midrst.no_valid", 16'(nv), 16'd0);
    run_op("div9_2", 1'b1, 8'd9, 8'd2, -1, -1, 1'b0);

    // Counter stuck at zero: forced completion and sticky error.
    stuck = 1'b1;
    run_op("stuck", 1'b0, 8'd13, 8'd11, -1, -1, 1'b1);
    run_op("stuck_sticky", 1'b1, 8'd100, 8'd9, -1, -1, 1'b1);
    stuck = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("err_cleared", 16'(err), 16'd0);
    run_op("after_err", 1'b0, 8'd7, 8'd9, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
